sudoku_puzzle_loader: RTL and testbench

Upstream stage of the Sudoku game core: on a load request, fetches one 81-cell puzzle from a synchronous puzzle ROM and assembles the packed 324-bit initial board and the 81-bit editable-cell mask. When the board is complete, it emits a one-cycle `start` pulse. The game core samples `init_board` and `init_board_blank` on that pulse. Both buses stay stable until the next accepted load.

---
 rtl/sudoku_pkg.sv | 23 ++
 rtl/sudoku_puzzle_loader_if.sv | 23 ++
 rtl/sudoku_lat_pipe.sv | 28 ++
 rtl/sudoku_puzzle_loader.sv | 150 +++++++++++++++
 tb/tb_sudoku_puzzle_loader.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared constants, FSM states and cell helpers
// for the Sudoku puzzle loader.
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int DIGIT_W = 4;
  localparam int BOARD_W = CELLS * DIGIT_W;
  localparam int IDX_W   = 7;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  function automatic int unsigned cell_lsb(
    input logic [IDX_W-1:0] i
  );
    return {25'd0, i} << 2;
  endfunction

endpackage

// File: rtl/sudoku_puzzle_loader_if.sv
// Puzzle ROM read port: address/enable out,
// nibble back after the ROM latency.
interface sudoku_puzzle_loader_if #(
  parameter int ADDR_W = 9
);

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [3:0]        rom_data;

  modport master (
    output rom_addr,
    output rom_en,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  rom_en,
    output rom_data
  );

endinterface

// File: rtl/sudoku_lat_pipe.sv
// Fixed-depth delay line that walks {valid, cell}
// alongside an in-flight ROM read.
module sudoku_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sudoku_puzzle_loader.sv
// Loads one 81-cell puzzle from ROM into the board.
// LOADER_RANDOM_EN: pick puzzle from a free-running counter.
module sudoku_puzzle_loader
  import sudoku_pkg::*;
#(
  parameter int NUM_PUZZLES = 4,
  parameter int ROM_LATENCY = 1,
  localparam int SEL_W =
    (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1,
  localparam int ADDR_W = $clog2(NUM_PUZZLES * CELLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_req,
  input  logic [SEL_W-1:0]   puzzle_sel,
  sudoku_puzzle_loader_if.master rom,
  output logic [BOARD_W-1:0] init_board,
  output logic [CELLS-1:0]   init_board_blank,
  output logic               start,
  output logic               busy,
  output logic               load_err
);

  localparam logic [SEL_W:0] SEL_MAX =
    (SEL_W+1)'(NUM_PUZZLES - 1);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(CELLS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_pick;
  logic             accept;
  logic             fetch;
  logic [ADDR_W-1:0] base;
  logic             cap_valid;
  logic [IDX_W-1:0] cap_idx;
  logic [3:0]       nib;
  logic             bad;

`ifdef LOADER_RANDOM_EN
  logic [SEL_W-1:0] rnd_q;

  always_ff @(posedge clk) begin
    if (reset)
      rnd_q <= '0;
    else if (rnd_q == SEL_MAX[SEL_W-1:0])
      rnd_q <= '0;
    else
      rnd_q <= rnd_q + SEL_W'(1);
  end

  assign sel_pick = rnd_q;
`else
  assign sel_pick =
    ({1'b0, puzzle_sel} > SEL_MAX) ?
    SEL_MAX[SEL_W-1:0] : puzzle_sel;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    busy    = 1'b1;
    fetch   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (load_req) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fetch = 1'b1;
        if (cnt_q == LAST)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_valid && cap_idx == LAST)
          state_d = DONE;
      end
      DONE: begin
        start   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
      sel_q <= sel_pick;
    end else if (fetch) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  assign base = ADDR_W'(sel_q) * ADDR_W'(CELLS);

  assign rom.rom_en   = fetch;
  assign rom.rom_addr =
    fetch ? base + ADDR_W'(cnt_q) : '0;

  sudoku_lat_pipe #(
    .DEPTH (ROM_LATENCY),
    .W     (IDX_W + 1)
  ) u_lat_pipe (
    .clk   (clk),
    .reset (reset),
    .d     ({fetch, cnt_q}),
    .q     ({cap_valid, cap_idx})
  );

  assign nib = rom.rom_data;
  assign bad = nib > 4'd9;

  // Out-of-range digits become editable blanks.
  always_ff @(posedge clk) begin
    if (reset) begin
      init_board       <= '0;
      init_board_blank <= '0;
      load_err         <= 1'b0;
    end else begin
      if (accept)
        load_err <= 1'b0;
      if (cap_valid) begin
        init_board[cell_lsb(cap_idx) +: DIGIT_W] <=
          bad ? 4'd0 : nib;
        init_board_blank[cap_idx] <=
          bad || (nib == 4'd0);
        if (bad)
          load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Directed bench: two loader instances (4 puzzles/lat 1,
// 3 puzzles/lat 3) against behavioural ROMs.
module tb_sudoku_puzzle_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         a_load = 1'b0;
  logic [1:0]   a_sel = '0;
  logic [323:0] a_board;
  logic [80:0]  a_blank;
  logic         a_start, a_busy, a_err;

  logic         b_load = 1'b0;
  logic [1:0]   b_sel = '0;
  logic [323:0] b_board;
  logic [80:0]  b_blank;
  logic         b_start, b_busy, b_err;

  sudoku_puzzle_loader_if #(.ADDR_W(9)) a_rom ();
  sudoku_puzzle_loader_if #(.ADDR_W(8)) b_rom ();

  sudoku_puzzle_loader #(
    .NUM_PUZZLES(4), .ROM_LATENCY(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .load_req(a_load), .puzzle_sel(a_sel),
    .rom(a_rom),
    .init_board(a_board), .init_board_blank(a_blank),
    .start(a_start), .busy(a_busy), .load_err(a_err)
  );

  sudoku_puzzle_loader #(
    .NUM_PUZZLES(3), .ROM_LATENCY(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .load_req(b_load), .puzzle_sel(b_sel),
    .rom(b_rom),
    .init_board(b_board), .init_board_blank(b_blank),
    .start(b_start), .busy(b_busy), .load_err(b_err)
  );

  logic [3:0] mem_a [324];
  logic [3:0] mem_b [243];
  logic [3:0] a_p0;
  logic [3:0] b_p0, b_p1, b_p2;

  always @(posedge clk) a_p0 <= mem_a[a_rom.rom_addr];
  assign a_rom.rom_data = a_p0;

  always @(posedge clk) begin
    b_p0 <= mem_b[b_rom.rom_addr];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_rom.rom_data = b_p2;

  function automatic logic [3:0] val_a(int p, int i);
    case (p)
      0: return 4'(i % 10);
      1: return (i == 40) ? 4'd12 : 4'((i % 9) + 1);
      2: return 4'((i * 7) % 10);
      default: return 4'(9 - (i % 10));
    endcase
  endfunction

  function automatic logic [3:0] val_b(int p, int i);
    case (p)
      0: return 4'd1;
      1: return 4'd2;
      default: return 4'((i * 3) % 10);
    endcase
  endfunction

  logic [323:0] eb;
  logic [80:0]  ebl;

  task automatic model(input bit is_b, input int p);
    logic [3:0] v;
    for (int i = 0; i < 81; i++) begin
      v = is_b ? val_b(p, i) : val_a(p, i);
      if (v > 4'd9) v = 4'd0;
      eb[4*i +: 4] = v;
      ebl[i] = (v == 4'd0);
    end
  endtask

  int a_first_addr;
  logic a_first_en, a_first_busy;

  task automatic run_a(input logic [1:0] sel, output int lat);
    int n;
    @(negedge clk);
    a_sel = sel;
    a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    a_first_addr = int'(a_rom.rom_addr);
    a_first_en = a_rom.rom_en;
    a_first_busy = a_busy;
    lat = -1;
    n = 1;
    while (n <= 300) begin
      if (a_start) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_b(input logic [1:0] sel,
                       output int lat, output int first,
                       output int last, output int cnt,
                       output bit contig);
    int n;
    @(negedge clk);
    b_sel = sel;
    b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    lat = -1; first = -1; last = -1;
    cnt = 0; contig = 1'b1;
    n = 1;
    while (n <= 300) begin
      if (b_rom.rom_en) begin
        if (cnt == 0) first = int'(b_rom.rom_addr);
        else if (int'(b_rom.rom_addr) != last + 1)
          contig = 1'b0;
        last = int'(b_rom.rom_addr);
        cnt++;
      end
      if (b_start) begin
        lat = n;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_board, a_blank, a_start, a_busy, a_err,
         a_rom.rom_en, a_rom.rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs not zero start=%b busy=%b en=%b addr=%0d",
               a_start, a_busy, a_rom.rom_en, a_rom.rom_addr);
    end
    checks++;
    if ({b_board, b_blank, b_start, b_busy, b_err,
         b_rom.rom_en, b_rom.rom_addr} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs not zero start=%b busy=%b en=%b addr=%0d",
               b_start, b_busy, b_rom.rom_en, b_rom.rom_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    run_a(2'd0, lat);
    model(1'b0, 0);
    checks++;
    if (lat !== 83) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 83", lat);
    end
    checks++;
    if (a_first_addr !== 0 || a_first_en !== 1'b1 ||
        a_first_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_issue: addr=%0d en=%b busy=%b want 0 1 1",
               a_first_addr, a_first_en, a_first_busy);
    end
    checks++;
    if (a_board[3:0] !== 4'd0 || a_board[7:4] !== 4'd1) begin
      errors++;
      $display("FAIL basic_cells01: got %0d %0d want 0 1",
               a_board[3:0], a_board[7:4]);
    end
    checks++;
    if (a_blank !== ebl) begin
      errors++;
      $display("FAIL basic_blank: got %h want %h", a_blank, ebl);
    end
    checks++;
    if (a_board !== eb) begin
      errors++;
      $display("FAIL basic_board: got %h want %h", a_board, eb);
    end
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: got %b want 0", a_err);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_start !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b start=%b want 0 0",
               a_busy, a_start);
    end
  endtask

  task automatic test_error();
    int lat;
    run_a(2'd1, lat);
    checks++;
    if (a_board[163:160] !== 4'd0 || a_blank[40] !== 1'b1) begin
      errors++;
      $display("FAIL err_cell40: val=%0d blank=%b want 0 1",
               a_board[163:160], a_blank[40]);
    end
    checks++;
    if (a_blank !== (81'd1 << 40)) begin
      errors++;
      $display("FAIL err_blank: got %h want only bit 40", a_blank);
    end
    checks++;
    if (a_err !== 1'b1 || lat !== 83) begin
      errors++;
      $display("FAIL err_flag: err=%b lat=%0d want 1 83", a_err, lat);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b want 1", a_err);
    end
    run_a(2'd2, lat);
    model(1'b0, 2);
    checks++;
    if (a_err !== 1'b0 || a_board !== eb) begin
      errors++;
      $display("FAIL err_clear: err=%b board_ok=%b want 0 1",
               a_err, a_board === eb);
    end
  endtask

  task automatic test_ignore();
    int nst, first;
    nst = 0; first = -1;
    @(negedge clk);
    a_sel = 2'd3;
    a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (n == 30) begin
        a_load = 1'b1;
        a_sel = 2'd1;
      end
      if (n == 31) a_load = 1'b0;
      if (a_start) begin
        nst++;
        if (first < 0) begin
          first = n;
          model(1'b0, 3);
          checks++;
          if (a_board !== eb) begin
            errors++;
            $display("FAIL ignore_board: got %h want %h", a_board, eb);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (nst !== 1 || first !== 83) begin
      errors++;
      $display("FAIL ignore_starts: count=%0d first=%0d want 1 83",
               nst, first);
    end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    s1 = -1; s2 = -1;
    @(negedge clk);
    a_sel = 2'd0;
    a_load = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 400; n++) begin
      if (a_start) begin
        if (s1 < 0) s1 = n;
        else begin
          s2 = n;
          a_load = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    a_load = 1'b0;
    checks++;
    if (s1 !== 83 || (s2 - s1) !== 84) begin
      errors++;
      $display("FAIL b2b_timing: first=%0d gap=%0d want 83 84",
               s1, s2 - s1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_reset_mid();
    int nst;
    nst = 0;
    @(negedge clk);
    a_sel = 2'd0;
    a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    for (int n = 1; n < 50; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_board, a_blank, a_start, a_busy, a_err,
         a_rom.rom_en, a_rom.rom_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_zero: busy=%b en=%b addr=%0d board_nz=%b",
               a_busy, a_rom.rom_en, a_rom.rom_addr, |a_board);
    end
    reset = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (a_start) nst++;
      @(negedge clk);
    end
    checks++;
    if (nst !== 0 || a_busy !== 1'b0 || a_blank !== '0) begin
      errors++;
      $display("FAIL midreset_quiet: starts=%0d busy=%b want 0 0",
               nst, a_busy);
    end
  endtask

  task automatic test_latency3();
    int lat, f, l, c;
    bit ok;
    run_b(2'd2, lat, f, l, c, ok);
    model(1'b1, 2);
    checks++;
    if (lat !== 85) begin
      errors++;
      $display("FAIL lat3_latency: got %0d want 85", lat);
    end
    checks++;
    if (f !== 162 || l !== 242 || c !== 81 || !ok) begin
      errors++;
      $display("FAIL lat3_addr: first=%0d last=%0d n=%0d contig=%b want 162 242 81 1",
               f, l, c, ok);
    end
    checks++;
    if (b_board !== eb || b_blank !== ebl) begin
      errors++;
      $display("FAIL lat3_board: got %h want %h", b_board, eb);
    end
  endtask

  task automatic test_clamp();
    int lat, f, l, c;
    bit ok;
    run_b(2'd0, lat, f, l, c, ok);
    checks++;
    if (b_board[3:0] !== 4'd1 || f !== 0) begin
      errors++;
      $display("FAIL clamp_pre: cell0=%0d first=%0d want 1 0",
               b_board[3:0], f);
    end
    run_b(2'd3, lat, f, l, c, ok);
    model(1'b1, 2);
    checks++;
    if (f !== 162 || l !== 242 || c !== 81 || !ok) begin
      errors++;
      $display("FAIL clamp_addr: first=%0d last=%0d n=%0d contig=%b want 162 242 81 1",
               f, l, c, ok);
    end
    checks++;
    if (b_board !== eb || lat !== 85) begin
      errors++;
      $display("FAIL clamp_board: lat=%0d board_ok=%b want 85 1",
               lat, b_board === eb);
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 81; i++)
        mem_a[p*81 + i] = val_a(p, i);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 81; i++)
        mem_b[p*81 + i] = val_b(p, i);
    test_reset();
    test_basic();
    test_error();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_latency3();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
